// File: rtl/freq_ctrl_pkg.sv
// Shared types, default timing and the PINC rounding helper for the key-driven
// DDS frequency controller.
package freq_ctrl_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_PRESS  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // 50 MHz clock: 20 ms debounce, 0.5 s hold, 0.1 s repeat
  localparam int unsigned DEB_CYCLES_DEF    = 1_000_000;
  localparam int unsigned HOLD_CYCLES_DEF   = 25_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 5_000_000;
  localparam int unsigned PINC_K_DEF        = 41943;
  localparam int unsigned PINC_SH_DEF       = 10;

  // Round-to-nearest fixed-point scaling: (code * k + 2^(sh-1)) >> sh.
  function automatic logic [63:0] pinc_round(input logic [63:0] code,
                                             input logic [63:0] k,
                                             input int unsigned sh);
    logic [63:0] half;
    half = (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
    return (code * k + half) >> sh;
  endfunction

endpackage

// File: rtl/freq_ctrl_param_key.sv
// One push-button channel: 2-FF synchroniser, debounce, and the
// press / hold / auto-repeat event generator with an external inhibit.
module key_rpt_debounce
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       key_raw,
  input  logic       inhibit,
  output logic       clean_level,
  output logic       evt,
  output rpt_state_t state
);

  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          clean_d;
  logic          fall;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] rpt_cnt, rpt_cnt_n;
  rpt_state_t    state_n;

  // Levels are active-low; everything resets to "released".
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      clean_level <= 1'b1;
      clean_d     <= 1'b1;
      deb_cnt     <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_raw};
      clean_d <= clean_level;
      if (sync_q[1] != clean_level) begin
        if (deb_cnt == DEB_LAST) begin
          clean_level <= sync_q[1];
          deb_cnt     <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign fall = clean_d & ~clean_level;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RPT_IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_n;
      rpt_cnt <= rpt_cnt_n;
    end
  end

  // Inhibit wins over everything: it parks the FSM and swallows events.
  always_comb begin
    state_n   = state;
    rpt_cnt_n = '0;
    evt       = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (fall && !inhibit) begin
          state_n = RPT_PRESS;
          evt     = 1'b1;
        end
      end
      RPT_PRESS: begin
        if (inhibit || clean_level) begin
          state_n = RPT_IDLE;
        end else if (rpt_cnt == HOLD_LAST) begin
          state_n = RPT_REPEAT;
          evt     = 1'b1;
        end else begin
          rpt_cnt_n = rpt_cnt + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (inhibit || clean_level) begin
          state_n = RPT_IDLE;
        end else if (rpt_cnt == REP_LAST) begin
          evt = 1'b1;
        end else begin
          rpt_cnt_n = rpt_cnt + 1'b1;
        end
      end
      default: state_n = RPT_IDLE;
    endcase
  end

endmodule

// File: rtl/freq_ctrl_param.sv
// Two-key frequency code controller: steps a bounded code from debounced keys
// and ships the matching DDS phase increment over an AXI-Stream config port.
module freq_ctrl_param
  import freq_ctrl_pkg::*;
#(
  parameter int          CODE_W        = 6,
  parameter int unsigned FREQ_MIN      = 1,
  parameter int unsigned FREQ_MAX      = 30,
  parameter int unsigned FREQ_DEF      = 1,
  parameter int unsigned WRAP          = 1,
  parameter int          PHASE_W       = 24,
  parameter int unsigned PINC_K        = PINC_K_DEF,
  parameter int unsigned PINC_SH       = PINC_SH_DEF,
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic               clk_50m,
  input  logic               rst_n,
  input  logic [1:0]         key,
  output logic [CODE_W-1:0]  freq_code,
  output logic               step_pulse,
  output logic [PHASE_W-1:0] cfg_tdata,
  output logic               cfg_tvalid,
  input  logic               cfg_tready
);

  if (!(FREQ_MIN <= FREQ_DEF && FREQ_DEF <= FREQ_MAX && 64'(FREQ_MAX) < (64'd1 << CODE_W)))
    begin : g_bad_range
      $error("freq_ctrl_param: code limits out of range");
    end
  if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
    $error("freq_ctrl_param: timing parameters must be >= 1");
  end
  if (PHASE_W > 64 || PINC_SH > 63) begin : g_bad_pinc
    $error("freq_ctrl_param: PINC widths exceed 64 bits");
  end

  localparam logic [CODE_W-1:0] C_MIN = CODE_W'(FREQ_MIN);
  localparam logic [CODE_W-1:0] C_MAX = CODE_W'(FREQ_MAX);
  localparam logic [CODE_W-1:0] C_DEF = CODE_W'(FREQ_DEF);

  logic               dn_level, up_level, dn_evt, up_evt;
  rpt_state_t         dn_state, up_state;
  logic               lock, lock_n;
  logic [CODE_W-1:0]  code_n;
  logic               changed;
  logic [PHASE_W-1:0] pinc_q;
  logic               pinc_stale;
  logic               pending;
  logic               load;

  key_rpt_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_dn (
    .clk_50m(clk_50m), .rst_n(rst_n), .key_raw(key[0]), .inhibit(lock),
    .clean_level(dn_level), .evt(dn_evt), .state(dn_state)
  );

  key_rpt_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_up (
    .clk_50m(clk_50m), .rst_n(rst_n), .key_raw(key[1]), .inhibit(lock),
    .clean_level(up_level), .evt(up_evt), .state(up_state)
  );

  // An event while the other key is held (or both events at once) is the
  // two-key reset; the lock holds both channels idle until both are released.
  always_comb begin
    code_n = freq_code;
    lock_n = lock;
    if (lock && up_level && dn_level && up_state == RPT_IDLE && dn_state == RPT_IDLE)
      lock_n = 1'b0;
    if ((up_evt && (dn_evt || !dn_level)) || (dn_evt && !up_level)) begin
      code_n = C_DEF;
      lock_n = 1'b1;
    end else if (up_evt) begin
      if (freq_code == C_MAX) code_n = (WRAP != 0) ? C_MIN : freq_code;
      else                    code_n = freq_code + 1'b1;
    end else if (dn_evt) begin
      if (freq_code == C_MIN) code_n = (WRAP != 0) ? C_MAX : freq_code;
      else                    code_n = freq_code - 1'b1;
    end
  end

  assign changed = (code_n != freq_code);

  // Config port: cfg_tdata is frozen while cfg_tvalid is high and the beat
  // completes on cfg_tvalid & cfg_tready. A new word is loaded only while idle,
  // once the PINC register reflects the current code; code changes during an
  // outstanding beat leave pending set so only the latest code follows.
  assign load = !cfg_tvalid && pending && !pinc_stale;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      freq_code  <= C_DEF;
      step_pulse <= 1'b0;
      lock       <= 1'b0;
      pinc_q     <= '0;
      pinc_stale <= 1'b1;
      pending    <= 1'b1;
      cfg_tvalid <= 1'b0;
      cfg_tdata  <= '0;
    end else begin
      freq_code  <= code_n;
      step_pulse <= changed;
      lock       <= lock_n;
      pinc_q     <= PHASE_W'(pinc_round(64'(freq_code), 64'(PINC_K), PINC_SH));
      pinc_stale <= changed;
      if (changed)   pending <= 1'b1;
      else if (load) pending <= 1'b0;
      if (cfg_tvalid && cfg_tready) begin
        cfg_tvalid <= 1'b0;
      end else if (load) begin
        cfg_tvalid <= 1'b1;
        cfg_tdata  <= pinc_q;
      end
    end
  end

endmodule

// File: tb/tb_freq_ctrl_param.sv
// Directed bench for freq_ctrl_param: a code/transfer model checked every cycle
// plus literal expectations at the end of each scenario.
module tb_freq_ctrl_param;
  import freq_ctrl_pkg::*;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  key = 2'b11, key_s = 2'b11;
  logic        cfg_tready = 1'b1, cfg_tready_s = 1'b1;
  logic [5:0]  freq_code, freq_code_s;
  logic        step_pulse, step_pulse_s;
  logic [23:0] cfg_tdata, cfg_tdata_s;
  logic        cfg_tvalid, cfg_tvalid_s;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_code_q[$];
  logic [31:0] exp_xfer_q[$];
  int model_code = 1;

  logic [5:0]  prev_code;
  logic        prev_v, prev_r;
  logic [23:0] prev_d, last_xfer, sat_last;
  int xfer_cnt, pulse_cnt, sat_pulses, sat_xfers;

  freq_ctrl_param #(.DEB_CYCLES(4), .HOLD_CYCLES(40), .REPEAT_CYCLES(10), .WRAP(1)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .key(key), .freq_code(freq_code),
    .step_pulse(step_pulse), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready)
  );

  freq_ctrl_param #(.DEB_CYCLES(4), .HOLD_CYCLES(40), .REPEAT_CYCLES(10), .WRAP(0)) dut_sat (
    .clk_50m(clk_50m), .rst_n(rst_n), .key(key_s), .freq_code(freq_code_s),
    .step_pulse(step_pulse_s), .cfg_tdata(cfg_tdata_s), .cfg_tvalid(cfg_tvalid_s),
    .cfg_tready(cfg_tready_s)
  );

  // clock / reset
  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0d, expected nothing", name, act);
  endtask

  // model
  function automatic logic [31:0] pinc_exp(input int code);
    return 32'(pinc_round(64'(code), 64'd41943, 10));
  endfunction

  function automatic int next_code(input int c, input bit up);
    if (up) return (c == 30) ? 1 : c + 1;
    return (c == 1) ? 30 : c - 1;
  endfunction

  task automatic model_event(input bit up, input bit with_xfer);
    int n;
    n = next_code(model_code, up);
    if (n != model_code) begin
      model_code = n;
      exp_code_q.push_back(32'(n));
      if (with_xfer) exp_xfer_q.push_back(pinc_exp(n));
    end
  endtask

  task automatic model_both_reset();
    if (model_code != 1) begin
      model_code = 1;
      exp_code_q.push_back(32'd1);
      exp_xfer_q.push_back(pinc_exp(1));
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #2;
    end
  endtask

  task automatic press(input int idx, input int n_low, input int n_gap);
    key[idx] = 1'b0;
    tick(n_low);
    key[idx] = 1'b1;
    tick(n_gap);
  endtask

  task automatic press_step(input bit up);
    model_event(up, 1'b1);
    press(up ? 1 : 0, 20, 20);
  endtask

  // scoreboard / compare process
  always @(negedge clk_50m) begin
    if (!rst_n) begin
      prev_code = 6'd1;
      prev_v    = 1'b0;
      prev_r    = 1'b0;
      prev_d    = '0;
      last_xfer = '0;
      xfer_cnt  = 0;
      pulse_cnt = 0;
    end else begin
      if (step_pulse) pulse_cnt++;
      if (freq_code != prev_code) begin
        check("step_pulse_on_change", 32'(step_pulse), 32'd1);
        if (exp_code_q.size() == 0) fail_unexpected("unexpected_code_change", 32'(freq_code));
        else check("freq_code_seq", 32'(freq_code), exp_code_q.pop_front());
      end else begin
        check("step_pulse_quiet", 32'(step_pulse), 32'd0);
      end
      if (prev_v && !prev_r) begin
        check("tvalid_held", 32'(cfg_tvalid), 32'd1);
        check("tdata_held", 32'(cfg_tdata), 32'(prev_d));
      end
      if (cfg_tvalid && cfg_tready) begin
        xfer_cnt++;
        last_xfer = cfg_tdata;
        if (exp_xfer_q.size() == 0) fail_unexpected("unexpected_transfer", 32'(cfg_tdata));
        else check("cfg_tdata_xfer", 32'(cfg_tdata), exp_xfer_q.pop_front());
      end
      prev_code = freq_code;
      prev_v    = cfg_tvalid;
      prev_r    = cfg_tready;
      prev_d    = cfg_tdata;
    end
  end

  always @(negedge clk_50m) begin
    if (!rst_n) begin
      sat_pulses = 0;
      sat_xfers  = 0;
      sat_last   = '0;
    end else begin
      if (step_pulse_s) sat_pulses++;
      if (cfg_tvalid_s && cfg_tready_s) begin
        sat_xfers++;
        sat_last = cfg_tdata_s;
      end
    end
  end

  initial begin
    // reset release and first transfer
    exp_xfer_q.push_back(pinc_exp(1));
    tick(3);
    #3 rst_n = 1'b1;
    @(negedge clk_50m);
    check("reset_code", 32'(freq_code), 32'd1);
    check("reset_step_pulse", 32'(step_pulse), 32'd0);
    check("reset_tvalid", 32'(cfg_tvalid), 32'd0);
    @(negedge clk_50m);
    check("tvalid_cycle1", 32'(cfg_tvalid), 32'd0);
    @(negedge clk_50m);
    check("tvalid_cycle2", 32'(cfg_tvalid), 32'd1);
    check("tdata_cycle2", 32'(cfg_tdata), 32'd41);
    @(negedge clk_50m);
    check("tvalid_cycle3", 32'(cfg_tvalid), 32'd0);

    // saturating instance: down at the floor holds, up still steps
    tick(1);
    key_s[0] = 1'b0; tick(20); key_s[0] = 1'b1; tick(20);
    check("sat_code_floor", 32'(freq_code_s), 32'd1);
    check("sat_pulses_floor", 32'(sat_pulses), 32'd0);
    check("sat_xfers_floor", 32'(sat_xfers), 32'd1);
    key_s[1] = 1'b0; tick(20); key_s[1] = 1'b1; tick(20);
    check("sat_code_up", 32'(freq_code_s), 32'd2);
    check("sat_pulses_up", 32'(sat_pulses), 32'd1);
    check("sat_tdata_up", 32'(sat_last), 32'd82);

    // glitchy up press gives one step
    model_event(1'b1, 1'b1);
    key[1] = 1'b0; tick(2); key[1] = 1'b1; tick(2);
    key[1] = 1'b0; tick(2); key[1] = 1'b1; tick(2);
    press(1, 20, 20);
    check("glitch_code", 32'(freq_code), 32'd2);
    check("glitch_pulses", 32'(pulse_cnt), 32'd1);
    check("glitch_xfers", 32'(xfer_cnt), 32'd2);
    check("glitch_tdata", 32'(last_xfer), 32'd82);

    // wrap at both limits
    press_step(1'b0);
    press_step(1'b0);
    check("wrap_down_code", 32'(freq_code), 32'd30);
    check("wrap_down_tdata", 32'(last_xfer), 32'd1229);
    press_step(1'b1);
    check("wrap_up_code", 32'(freq_code), 32'd1);
    repeat (4) press_step(1'b1);
    check("climb_code", 32'(freq_code), 32'd5);

    // hold 100 cycles: press event plus repeats at 40,50,...,90
    repeat (7) model_event(1'b1, 1'b1);
    press(1, 100, 60);
    check("hold_code", 32'(freq_code), 32'd12);
    check("hold_code_q_empty", 32'(exp_code_q.size()), 32'd0);

    // both keys: up held steps 19->20, down press resets to 1, no repeats
    repeat (7) press_step(1'b1);
    model_event(1'b1, 1'b1);
    key[1] = 1'b0;
    tick(15);
    model_both_reset();
    key[0] = 1'b0; tick(20); key[0] = 1'b1;
    tick(85);
    check("both_code_locked", 32'(freq_code), 32'd1);
    key[1] = 1'b1;
    tick(20);
    check("both_code", 32'(freq_code), 32'd1);
    check("both_tdata", 32'(last_xfer), 32'd41);
    press_step(1'b1);
    check("resume_code", 32'(freq_code), 32'd2);

    // stalled config port: only the latest code follows the held beat
    press_step(1'b0);
    begin
      int base;
      base = xfer_cnt;
      cfg_tready = 1'b0;
      exp_xfer_q.push_back(pinc_exp(2));
      exp_xfer_q.push_back(pinc_exp(4));
      repeat (3) begin
        model_event(1'b1, 1'b0);
        press(1, 20, 20);
      end
      @(negedge clk_50m);
      check("stall_code", 32'(freq_code), 32'd4);
      check("stall_tvalid", 32'(cfg_tvalid), 32'd1);
      check("stall_tdata", 32'(cfg_tdata), 32'd82);
      tick(1);
      cfg_tready = 1'b1;
      tick(10);
      check("stall_xfers", 32'(xfer_cnt - base), 32'd2);
      check("stall_last_tdata", 32'(last_xfer), 32'd164);
      check("stall_xfer_q_empty", 32'(exp_xfer_q.size()), 32'd0);
    end

    // reset in the middle of a stalled beat
    cfg_tready = 1'b0;
    model_event(1'b1, 1'b0);
    press(1, 20, 5);
    @(negedge clk_50m);
    check("midrst_tvalid_before", 32'(cfg_tvalid), 32'd1);
    check("midrst_tdata_before", 32'(cfg_tdata), 32'd205);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(cfg_tvalid), 32'd0);
    check("midrst_code", 32'(freq_code), 32'd1);
    model_code = 1;
    exp_xfer_q.push_back(pinc_exp(1));
    tick(2);
    #3 rst_n = 1'b1;
    cfg_tready = 1'b1;
    tick(10);
    check("midrst_tdata_after", 32'(last_xfer), 32'd41);
    check("final_code_q_empty", 32'(exp_code_q.size()), 32'd0);
    check("final_xfer_q_empty", 32'(exp_xfer_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
